mdu_iterative: RTL and testbench

Parametrised iterative multiply/divide unit for the EX stage, replacing single-cycle `*`, `/` and `%` evaluation in the ALU with a multi-cycle radix-2 datapath. It produces a full HI/LO result pair, exposes a start/busy/done handshake so the pipeline control can stall on it, and supports flush, for example on an exception or branch squash.

---
 rtl/mdu_pkg.sv | 26 ++
 rtl/mdu_step.sv | 38 +++
 rtl/mdu_iterative.sv | 154 +++++++++++++++
 tb/tb_mdu_iterative.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Holds the operation encoding, the FSM state encoding and small op decode helpers.
package mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'd0,
        MDU_MULTU = 2'd1,
        MDU_DIV   = 2'd2,
        MDU_DIVU  = 2'd3
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } mdu_state_e;

    function automatic logic op_is_div(input mdu_op_e o);
        return (o == MDU_DIV) || (o == MDU_DIVU);
    endfunction

    function automatic logic op_is_signed(input mdu_op_e o);
        return (o == MDU_MULT) || (o == MDU_DIV);
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration of the MDU datapath, purely combinational.
// Multiply: acc += multiplicand when the current multiplier bit is set. Divide: restoring trial subtract.
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [2*WIDTH-1:0]   opnd,
    input  logic [WIDTH-1:0]     mplr,
    output logic [2*WIDTH-1:0]   acc_nxt,
    output logic [2*WIDTH-1:0]   opnd_nxt,
    output logic [WIDTH-1:0]     mplr_nxt
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] diff;
    logic             fits;

    // Divide packs {remainder, dividend/quotient} into acc; the divisor sits in opnd[WIDTH-1:0].
    always_comb begin
        shifted  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        divisor  = opnd[WIDTH-1:0];
        fits     = (shifted >= {1'b0, divisor});
        diff     = shifted[WIDTH-1:0] - divisor;
        acc_nxt  = acc;
        opnd_nxt = opnd;
        mplr_nxt = mplr;
        if (is_div) begin
            acc_nxt = {(fits ? diff : shifted[WIDTH-1:0]), acc[WIDTH-2:0], fits};
        end else begin
            acc_nxt  = acc + (mplr[0] ? opnd : {(2*WIDTH){1'b0}});
            opnd_nxt = {opnd[2*WIDTH-2:0], 1'b0};
            mplr_nxt = {1'b0, mplr[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mdu_iterative.sv
// Iterative multiply/divide unit with start/busy/done handshake and flush.
// Optional build macro MDU_EARLY_OUT_EN ends multiplies once the remaining multiplier bits are zero.
//
//   state | meaning
//   IDLE  | waiting for a request (also the done cycle)
//   RUN   | one radix-2 iteration per cycle
//   FIX   | sign correction, results registered, done raised
module mdu_iterative
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH);

    mdu_state_e         state;
    mdu_op_e            op_r;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] opnd;
    logic [WIDTH-1:0]   mplr;
    logic               neg_p;
    logic               neg_r;
    logic               dz_r;

    mdu_op_e            req_op;
    logic               req_div;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic               last_iter;

    logic [2*WIDTH-1:0] acc_nxt;
    logic [2*WIDTH-1:0] opnd_nxt;
    logic [WIDTH-1:0]   mplr_nxt;

    assign req_op  = mdu_op_e'(op);
    assign req_div = op_is_div(req_op);
    assign a_neg   = op_is_signed(req_op) & op_a[WIDTH-1];
    assign b_neg   = op_is_signed(req_op) & op_b[WIDTH-1];
    assign a_abs   = a_neg ? -op_a : op_a;
    assign b_abs   = b_neg ? -op_b : op_b;

`ifdef MDU_EARLY_OUT_EN
    assign last_iter = (cnt == CW'(WIDTH - 1)) || (!op_is_div(op_r) && (mplr_nxt == '0));
`else
    assign last_iter = (cnt == CW'(WIDTH - 1));
`endif

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (op_is_div(op_r)),
        .acc      (acc),
        .opnd     (opnd),
        .mplr     (mplr),
        .acc_nxt  (acc_nxt),
        .opnd_nxt (opnd_nxt),
        .mplr_nxt (mplr_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            op_r     <= MDU_MULT;
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            mplr     <= '0;
            neg_p    <= 1'b0;
            neg_r    <= 1'b0;
            dz_r     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            op_r  <= req_op;
                            busy  <= 1'b1;
                            cnt   <= '0;
                            neg_p <= a_neg ^ b_neg;
                            neg_r <= a_neg;
                            if (req_div) begin
                                opnd <= {{WIDTH{1'b0}}, b_abs};
                                mplr <= '0;
                                // Divide by zero keeps the raw dividend for hi and skips RUN.
                                if (op_b == '0) begin
                                    acc   <= {{WIDTH{1'b0}}, op_a};
                                    dz_r  <= 1'b1;
                                    state <= FIX;
                                end else begin
                                    acc   <= {{WIDTH{1'b0}}, a_abs};
                                    dz_r  <= 1'b0;
                                    state <= RUN;
                                end
                            end else begin
                                acc   <= '0;
                                opnd  <= {{WIDTH{1'b0}}, a_abs};
                                mplr  <= b_abs;
                                dz_r  <= 1'b0;
                                state <= RUN;
                            end
                        end
                    end
                    RUN: begin
                        acc  <= acc_nxt;
                        opnd <= opnd_nxt;
                        mplr <= mplr_nxt;
                        cnt  <= cnt + 1'b1;
                        if (last_iter) state <= FIX;
                    end
                    FIX: begin
                        if (dz_r) begin
                            hi <= acc[WIDTH-1:0];
                            lo <= '1;
                        end else if (op_is_div(op_r)) begin
                            lo <= neg_p ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                            hi <= neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
                        end else begin
                            {hi, lo} <= neg_p ? -acc : acc;
                        end
                        div_zero <= dz_r;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative (WIDTH=32) using a result scoreboard.
// Expected latencies follow MDU_EARLY_OUT_EN when the bench is built with it.
module tb_mdu_iterative;
    import mdu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic [1:0]   op = 2'd0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           lat;
    } exp_t;

    exp_t sb[$];
    exp_t last_e;
    int   n_checks = 0;
    int   n_pass = 0;

    mdu_iterative #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
        .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        longint sa, sbv, q, r;
        logic [2*W-1:0] p;
        logic [W-1:0] babs;
        int n;
        e.dz = 1'b0;
        e.lat = W + 1;
        sa = longint'($signed(a));
        sbv = longint'($signed(b));
        p = '0;
        q = 0;
        r = 0;
        case (o)
            2'd0: begin p = sa * sbv; e.hi = p[2*W-1:W]; e.lo = p[W-1:0]; end
            2'd1: begin p = {32'b0, a} * {32'b0, b}; e.hi = p[2*W-1:W]; e.lo = p[W-1:0]; end
            default: begin
                if (b == '0) begin
                    e.hi = a; e.lo = '1; e.dz = 1'b1; e.lat = 1;
                end else if (o == 2'd2 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    e.hi = '0; e.lo = 32'h8000_0000;
                end else if (o == 2'd2) begin
                    q = sa / sbv; r = sa % sbv; e.lo = q[W-1:0]; e.hi = r[W-1:0];
                end else begin
                    e.lo = a / b; e.hi = a % b;
                end
            end
        endcase
`ifdef MDU_EARLY_OUT_EN
        if (o < 2'd2) begin
            babs = (o == 2'd0 && b[W-1]) ? -b : b;
            n = 1;
            for (int i = 0; i < W; i++) if (babs[i]) n = i + 1;
            e.lat = n + 1;
        end
`endif
        return e;
    endfunction

    // Drives one request; returns #1 after its accept edge.
    task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit push, input bit hold);
        @(negedge clk);
        op = o; op_a = a; op_b = b; start = 1'b1;
        if (push) sb.push_back(model(o, a, b));
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
    endtask

    // Called #1 after an accept edge: waits for done, pops the scoreboard and compares.
    task automatic wait_check(input string name);
        exp_t e;
        int k, bcyc;
        bit seen;
        k = 0; bcyc = 0; seen = 1'b0;
        if (busy) bcyc++;
        while (!seen && k < 100) begin
            @(posedge clk); #1; k++;
            if (done) seen = 1'b1;
            else if (busy) bcyc++;
        end
        n_checks++;
        if (sb.size() == 0) begin
            $display("FAIL %s scoreboard empty", name);
            return;
        end
        e = sb.pop_front();
        if (!seen) begin
            $display("FAIL %s timeout: no done within %0d edges, required %0d", name, k, e.lat);
            return;
        end
        n_pass++;
        n_checks++; if (k != e.lat) $display("FAIL %s latency got %0d exp %0d", name, k, e.lat); else n_pass++;
        n_checks++; if (bcyc != e.lat) $display("FAIL %s busy cycles got %0d exp %0d", name, bcyc, e.lat); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL %s busy in done cycle got %b exp 0", name, busy); else n_pass++;
        n_checks++; if (hi !== e.hi) $display("FAIL %s hi got %h exp %h", name, hi, e.hi); else n_pass++;
        n_checks++; if (lo !== e.lo) $display("FAIL %s lo got %h exp %h", name, lo, e.lo); else n_pass++;
        n_checks++; if (div_zero !== e.dz) $display("FAIL %s div_zero got %b exp %b", name, div_zero, e.dz); else n_pass++;
        last_e = e;
        @(posedge clk); #1;
        n_checks++; if (done !== 1'b0) $display("FAIL %s done pulse width got %b exp 0", name, done); else n_pass++;
    endtask

    task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        issue(o, a, b, 1'b1, 1'b0);
        wait_check(name);
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if ({busy, done, div_zero} !== 3'b000) $display("FAIL reset flags got %b exp 000", {busy, done, div_zero}); else n_pass++;
        n_checks++; if ({hi, lo} !== '0) $display("FAIL reset hilo got %h exp 0", {hi, lo}); else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_multu_max();
        run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    endtask

    task automatic test_signed();
        logic [1:0] o;
        logic [W-1:0] a, b;
        run_op("mult_neg3x5", 2'd0, -32'sd3, 32'd5);
        run_op("div_neg7by2", 2'd2, -32'sd7, 32'd2);
        run_op("div_min_by_m1", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("mult_min_sq", 2'd0, 32'h8000_0000, 32'h8000_0000);
        run_op("div_7_by_neg2", 2'd2, 32'd7, -32'sd2);
        for (int i = 0; i < 6; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = ($urandom_range(0, 1) == 0) ? W'($urandom_range(1, 300)) : $urandom;
            run_op("random_op", o, a, b);
        end
    endtask

    task automatic test_div_zero();
        run_op("divu_7by0", 2'd3, 32'd7, 32'd0);
        run_op("divu_7by2", 2'd3, 32'd7, 32'd2);
        run_op("div_neg5by0", 2'd2, -32'sd5, 32'd0);
        repeat (5) @(negedge clk);
        n_checks++; if ({hi, lo, div_zero} !== {last_e.hi, last_e.lo, last_e.dz}) $display("FAIL hold got %h %h %b exp %h %h %b", hi, lo, div_zero, last_e.hi, last_e.lo, last_e.dz); else n_pass++;
    endtask

    task automatic test_flush();
        bit saw;
        run_op("pre_flush", 2'd1, 32'h0001_2345, 32'h0000_0777);
        issue(2'd2, 32'd1000, 32'd7, 1'b0, 1'b0);
        repeat (9) @(posedge clk);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        n_checks++; if ({busy, done} !== 2'b00) $display("FAIL flush busy/done got %b exp 00", {busy, done}); else n_pass++;
        saw = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (done) saw = 1'b1; end
        n_checks++; if (saw) $display("FAIL flush spurious done got 1 exp 0"); else n_pass++;
        n_checks++; if ({hi, lo} !== {last_e.hi, last_e.lo}) $display("FAIL flush hilo got %h exp %h", {hi, lo}, {last_e.hi, last_e.lo}); else n_pass++;
        @(negedge clk); start = 1'b1; flush = 1'b1; op = 2'd1; op_a = 32'd9; op_b = 32'd9;
        @(posedge clk); #1; start = 1'b0; flush = 1'b0;
        n_checks++; if (busy !== 1'b0) $display("FAIL flush_with_start busy got %b exp 0", busy); else n_pass++;
        run_op("after_flush", 2'd3, 32'd100, 32'd9);
    endtask

    task automatic test_reset_mid();
        bit saw;
        issue(2'd1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk); #1;
        n_checks++; if ({busy, done, div_zero, hi, lo} !== '0) $display("FAIL reset_mid outputs got %b%b%b %h %h exp all 0", busy, done, div_zero, hi, lo); else n_pass++;
        @(negedge clk); rst_n = 1'b1;
        saw = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (done || busy) saw = 1'b1; end
        n_checks++; if (saw) $display("FAIL reset_mid activity after reset got 1 exp 0"); else n_pass++;
    endtask

    task automatic test_back_to_back();
        issue(2'd0, 32'h1234_5678, -32'sd9, 1'b1, 1'b1);
        op = 2'd3; op_a = 32'd1000; op_b = 32'd7;
        sb.push_back(model(2'd3, 32'd1000, 32'd7));
        wait_check("b2b_first");
        start = 1'b0;
        wait_check("b2b_second");
    endtask

    task automatic test_early_out();
        run_op("multu_5x3", 2'd1, 32'd5, 32'd3);
        run_op("multu_5x0", 2'd1, 32'd5, 32'd0);
        run_op("mult_neg7xneg4", 2'd0, -32'sd7, -32'sd4);
    endtask

    initial begin
        test_reset();
        test_multu_max();
        test_signed();
        test_div_zero();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        test_early_out();
        n_checks++; if (sb.size() != 0) $display("FAIL scoreboard leftover got %0d exp 0", sb.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
